// File: rtl/servo_pkg.sv
// Shared definitions for the servo angle ramp slice.
// Contents: angle width and ceiling, servo count, ramp FSM state type,
// and small angle helpers (target clamp, absolute difference).
package servo_pkg;

  localparam int unsigned ANGLE_W       = 8;
  localparam int unsigned MAX_ANGLE_DEG = 180;
  localparam int unsigned NUM_SERVOS    = 4;

  typedef enum logic {
    StIdle,
    StRamp
  } ramp_state_e;

  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a,
                                                     input logic [ANGLE_W-1:0] max_a);
    return (a > max_a) ? max_a : a;
  endfunction

  function automatic logic [ANGLE_W-1:0] abs_diff(input logic [ANGLE_W-1:0] a,
                                                  input logic [ANGLE_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/servo_angle_step.sv
// One-servo step: moves cur toward tgt by at most STEP degrees when step_en_i is high.
// Ports:
//   cur_i     current commanded angle
//   tgt_i     target angle (already clamped to the ceiling)
//   step_en_i apply a step this cycle
//   next_o    next commanded angle (equals cur_i when step_en_i is low)
// Because a step never passes the target and the target is clamped, the result
// stays inside 0..ceiling without any further saturation.
module servo_angle_step
  import servo_pkg::*;
#(
  parameter int unsigned STEP = 2
) (
  input  logic [ANGLE_W-1:0] cur_i,
  input  logic [ANGLE_W-1:0] tgt_i,
  input  logic               step_en_i,
  output logic [ANGLE_W-1:0] next_o
);

  localparam logic [ANGLE_W:0]   StepW = (ANGLE_W + 1)'(STEP);
  localparam logic [ANGLE_W-1:0] Step8 = ANGLE_W'(STEP);

  logic signed [ANGLE_W:0] diff;
  logic        [ANGLE_W:0] mag;

  always_comb begin
    diff   = $signed({1'b0, tgt_i}) - $signed({1'b0, cur_i});
    mag    = diff[ANGLE_W] ? $unsigned(-diff) : $unsigned(diff);
    next_o = cur_i;
    if (step_en_i) begin
      if (mag <= StepW) begin
        next_o = tgt_i;
      end else if (diff[ANGLE_W]) begin
        next_o = cur_i - Step8;
      end else begin
        next_o = cur_i + Step8;
      end
    end
  end

endmodule

// File: rtl/servo_angle_ramp.sv
// Slew-rate limiter feeding servo_controller's four angle inputs.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   tgt_valid_i/tgt_ready_o target-set handshake (ready stays high after reset)
//   tgt_servoN_i            target angles, clamped to MAX_ANGLE on accept
//   servoN_angle_o          commanded angles, moved by at most STEP per tick
//   busy_o                  high while in the ramp state
//   step_tick_o             pulse on the cycle a step is applied
// Optional: define RAMP_DEADBAND_EN to ignore target changes smaller than DEADBAND.
module servo_angle_ramp
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned STEP_RATE_HZ = 50,
  parameter int unsigned STEP         = 2,
  parameter int unsigned HOME_ANGLE   = 90,
  parameter int unsigned MAX_ANGLE    = 180,
  parameter int unsigned DEADBAND     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tgt_valid_i,
  output logic               tgt_ready_o,
  input  logic [ANGLE_W-1:0] tgt_servo0_i,
  input  logic [ANGLE_W-1:0] tgt_servo1_i,
  input  logic [ANGLE_W-1:0] tgt_servo2_i,
  input  logic [ANGLE_W-1:0] tgt_servo3_i,
  output logic [ANGLE_W-1:0] servo0_angle_o,
  output logic [ANGLE_W-1:0] servo1_angle_o,
  output logic [ANGLE_W-1:0] servo2_angle_o,
  output logic [ANGLE_W-1:0] servo3_angle_o,
  output logic               busy_o,
  output logic               step_tick_o
);

  localparam int unsigned        TICK_CYCLES = CLK_FREQ / STEP_RATE_HZ;
  localparam int unsigned        CntW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0]    CntLast     = CntW'(TICK_CYCLES - 1);
  localparam logic [ANGLE_W-1:0] Home        = ANGLE_W'(HOME_ANGLE);
  localparam logic [ANGLE_W-1:0] MaxA        = ANGLE_W'(MAX_ANGLE);
  localparam logic [ANGLE_W-1:0] Db          = ANGLE_W'(DEADBAND);
`ifdef RAMP_DEADBAND_EN
  localparam bit DbEn = 1'b1;
`else
  localparam bit DbEn = 1'b0;
`endif

  ramp_state_e        state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               ready_q;
  logic               busy_q;
  logic [ANGLE_W-1:0] cur_q    [NUM_SERVOS];
  logic [ANGLE_W-1:0] cur_next [NUM_SERVOS];
  logic [ANGLE_W-1:0] tgt_q    [NUM_SERVOS];
  logic [ANGLE_W-1:0] tgt_d    [NUM_SERVOS];
  logic [ANGLE_W-1:0] tgt_in   [NUM_SERVOS];
  logic               accept;
  logic               step_en;
  logic               differ;

  assign tgt_in[0] = tgt_servo0_i;
  assign tgt_in[1] = tgt_servo1_i;
  assign tgt_in[2] = tgt_servo2_i;
  assign tgt_in[3] = tgt_servo3_i;

  assign accept  = tgt_valid_i && ready_q;
  assign step_en = (state_q == StRamp) && (cnt_q == CntLast);

  for (genvar g = 0; g < NUM_SERVOS; g++) begin : g_step
    servo_angle_step #(
      .STEP(STEP)
    ) u_step (
      .cur_i    (cur_q[g]),
      .tgt_i    (tgt_q[g]),
      .step_en_i(step_en),
      .next_o   (cur_next[g])
    );
  end

  // Target capture with clamp and optional jitter deadband.
  always_comb begin
    for (int i = 0; i < NUM_SERVOS; i++) begin
      tgt_d[i] = tgt_q[i];
      if (accept) begin
        if (!(DbEn && (abs_diff(clamp_angle(tgt_in[i], MaxA), tgt_q[i]) < Db))) begin
          tgt_d[i] = clamp_angle(tgt_in[i], MaxA);
        end
      end
    end
  end

  // Compare post-step angles with post-accept targets so both the idle entry
  // decision and the ramp exit decision see the values that will be registered.
  always_comb begin
    differ = 1'b0;
    for (int i = 0; i < NUM_SERVOS; i++) begin
      if (cur_next[i] != tgt_d[i]) differ = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (differ) state_d = StRamp;
      end
      StRamp: begin
        cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        // Leave only on a step; a retarget mid-ramp keeps the tick phase.
        if (step_en && !differ) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NUM_SERVOS; i++) begin
        cur_q[i] <= Home;
        tgt_q[i] <= Home;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
      busy_q  <= (state_d == StRamp);
      for (int i = 0; i < NUM_SERVOS; i++) begin
        cur_q[i] <= cur_next[i];
        tgt_q[i] <= tgt_d[i];
      end
    end
  end

  assign tgt_ready_o    = ready_q;
  assign busy_o         = busy_q;
  assign step_tick_o    = step_en;
  assign servo0_angle_o = cur_q[0];
  assign servo1_angle_o = cur_q[1];
  assign servo2_angle_o = cur_q[2];
  assign servo3_angle_o = cur_q[3];

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Directed bench for servo_angle_ramp with TICK_CYCLES = 10, STEP = 2.
module tb_servo_angle_ramp;

  logic       clk;
  logic       rst_n;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] t0, t1, t2, t3;
  logic [7:0] a0, a1, a2, a3;
  logic       busy;
  logic       step_tick;

  int n_total;
  int n_bad;

  servo_angle_ramp #(
    .CLK_FREQ    (1000),
    .STEP_RATE_HZ(100),
    .STEP        (2),
    .HOME_ANGLE  (90),
    .MAX_ANGLE   (180),
    .DEADBAND    (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tgt_valid_i   (tgt_valid),
    .tgt_ready_o   (tgt_ready),
    .tgt_servo0_i  (t0),
    .tgt_servo1_i  (t1),
    .tgt_servo2_i  (t2),
    .tgt_servo3_i  (t3),
    .servo0_angle_o(a0),
    .servo1_angle_o(a1),
    .servo2_angle_o(a2),
    .servo3_angle_o(a3),
    .busy_o        (busy),
    .step_tick_o   (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int v0, input int v1, input int v2, input int v3);
    t0 = 8'(v0); t1 = 8'(v1); t2 = 8'(v2); t3 = 8'(v3);
    tgt_valid = 1'b1;
    cycles(1);
    tgt_valid = 1'b0;
  endtask

  task automatic check_angles(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
    check({tag, ".s0"}, a0, e0);
    check({tag, ".s1"}, a1, e1);
    check({tag, ".s2"}, a2, e2);
    check({tag, ".s3"}, a3, e3);
  endtask

  // Wait (bounded) for busy to drop; returns cycles waited or -1.
  task automatic wait_idle(input int limit, output int waited);
    waited = -1;
    for (int i = 0; i < limit; i++) begin
      if (!busy) begin
        waited = i;
        break;
      end
      cycles(1);
    end
  endtask

  int pulses;
  int max_seen;
  int w;

  initial begin
    n_total = 0; n_bad = 0;
    rst_n = 1'b0; tgt_valid = 1'b0;
    t0 = 8'd0; t1 = 8'd0; t2 = 8'd0; t3 = 8'd0;

    // Reset state
    cycles(3);
    check_angles("rst", 90, 90, 90, 90);
    check("rst.busy", busy, 0);
    check("rst.ready", tgt_ready, 0);
    check("rst.tick", step_tick, 0);
    rst_n = 1'b1;
    #2;
    check("rel.ready_pre", tgt_ready, 0);
    cycles(1);
    check("rel.ready", tgt_ready, 1);
    check("rel.busy", busy, 0);

    // Equal targets: stay idle
    send(90, 90, 90, 90);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (busy || step_tick) pulses++;
      cycles(1);
    end
    check("eq.no_activity", pulses, 0);

    // Normal ramp
    send(100, 80, 90, 95);
    check("ramp.busy", busy, 1);
    cycles(8);
    check("ramp.tick_early", step_tick, 0);
    cycles(1);
    check_angles("ramp.pre1", 90, 90, 90, 90);
    check("ramp.tick1", step_tick, 1);
    cycles(1);
    check_angles("ramp.t1", 92, 88, 90, 92);
    check("ramp.tick_off", step_tick, 0);
    cycles(10);
    check("ramp.t2.s3", a3, 94);
    cycles(10);
    check_angles("ramp.t3", 96, 84, 90, 95);
    cycles(19);
    check("ramp.busy_pre", busy, 1);
    cycles(1);
    check_angles("ramp.t5", 100, 80, 90, 95);
    check("ramp.busy_fall", busy, 0);

    // Clamp and range
    send(250, 0, 180, 0);
    max_seen = 0;
    w = -1;
    for (int i = 0; i < 700; i++) begin
      if (a0 > max_seen) max_seen = a0;
      if (a1 > max_seen) max_seen = a1;
      if (a2 > max_seen) max_seen = a2;
      if (a3 > max_seen) max_seen = a3;
      if (!busy) begin
        w = i;
        break;
      end
      cycles(1);
    end
    check("clamp.settled", (w >= 0) ? 1 : 0, 1);
    check("clamp.max", max_seen, 180);
    check_angles("clamp.final", 180, 0, 180, 0);

    // Return home, then retarget mid-ramp
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(1);
    send(120, 90, 90, 90);
    cycles(10);
    check("rt.t1", a0, 92);
    cycles(4);
    send(100, 90, 90, 90);
    cycles(4);
    check("rt.pre2", a0, 92);
    cycles(1);
    check("rt.t2", a0, 94);
    wait_idle(200, w);
    check("rt.settled", (w >= 0) ? 1 : 0, 1);
    check("rt.final", a0, 100);

    // Asynchronous reset during a ramp
    send(150, 30, 90, 90);
    cycles(25);
    check("ar.moving", a0, 104);
    rst_n = 1'b0;
    #2;
    check_angles("ar.async", 90, 90, 90, 90);
    check("ar.busy", busy, 0);
    cycles(1);
    rst_n = 1'b1;
    cycles(1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy || step_tick) pulses++;
      cycles(1);
    end
    check("ar.idle", pulses, 0);
    check_angles("ar.hold", 90, 90, 90, 90);

`ifdef RAMP_DEADBAND_EN
    // Jitter below the deadband is ignored
    send(92, 90, 90, 90);
    check("db.small_busy", busy, 0);
    cycles(12);
    check("db.small_hold", a0, 90);
    send(93, 90, 90, 90);
    check("db.big_busy", busy, 1);
    cycles(10);
    check("db.big_t1", a0, 92);
    wait_idle(50, w);
    check("db.big_final", a0, 93);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
